// File: rtl/arbitro_alu.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional per-requester completed-operation counters are enabled with CONTADOR_OPS_EN.
module arbitro_alu #(
   parameter int ANCHO        = 32,
   parameter bit PRIO_INICIAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sol0_valida,
   output logic             sol0_lista,
   input  logic [5:0]       sol0_funct,
   input  logic [ANCHO-1:0] sol0_a,
   input  logic [ANCHO-1:0] sol0_b,
   input  logic             sol1_valida,
   output logic             sol1_lista,
   input  logic [5:0]       sol1_funct,
   input  logic [ANCHO-1:0] sol1_a,
   input  logic [ANCHO-1:0] sol1_b,
   output logic             resp0_valida,
   input  logic             resp0_acepta,
   output logic [ANCHO-1:0] resp0_resultado,
   output logic             resp0_error,
   output logic             resp1_valida,
   input  logic             resp1_acepta,
   output logic [ANCHO-1:0] resp1_resultado,
   output logic             resp1_error,
   output logic [ANCHO-1:0] alu_a,
   output logic [ANCHO-1:0] alu_b,
   output logic [2:0]       senial_ALU,
   input  logic [ANCHO-1:0] alu_resultado
`ifdef CONTADOR_OPS_EN
   ,
   output logic [15:0]      ops0_total,
   output logic [15:0]      ops1_total
`endif
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {LIBRE, EJEC, RESP} estado_t;

   estado_t          estado, estado_sig;
   logic             ultimo;
   logic             owner;
   logic [5:0]       funct_q;
   logic [ANCHO-1:0] a_q, b_q;
   logic [ANCHO-1:0] resultado_q;
   logic             error_q;

   logic             grant0, grant1;
   logic             aceptado;
   logic [2:0]       dec_code;
   logic             dec_error;

   // Round robin: on a tie the requester that was not served last wins.
   assign grant0 = (estado == LIBRE) && sol0_valida && (!sol1_valida || ultimo);
   assign grant1 = (estado == LIBRE) && sol1_valida && (!sol0_valida || !ultimo);
   assign aceptado = owner ? resp1_acepta : resp0_acepta;

   always_comb begin
      dec_code  = OP_NOP;
      dec_error = 1'b0;
      case (funct_q)
         6'b100000: dec_code = OP_ADD;
         6'b100010: dec_code = OP_SUB;
         6'b100100: dec_code = OP_AND;
         6'b100101: dec_code = OP_OR;
         6'b100110: dec_code = OP_XOR;
         default:   dec_error = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado      <= LIBRE;
         ultimo      <= ~PRIO_INICIAL;
         owner       <= 1'b0;
         funct_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         resultado_q <= '0;
         error_q     <= 1'b0;
      end else begin
         estado <= estado_sig;
         if (grant0 || grant1) begin
            owner   <= grant1;
            funct_q <= grant1 ? sol1_funct : sol0_funct;
            a_q     <= grant1 ? sol1_a : sol0_a;
            b_q     <= grant1 ? sol1_b : sol0_b;
         end
         if (estado == EJEC) begin
            resultado_q <= dec_error ? '0 : alu_resultado;
            error_q     <= dec_error;
         end
         if (estado == RESP && aceptado)
            ultimo <= owner;
      end
   end

   always_comb begin
      estado_sig   = estado;
      sol0_lista   = 1'b0;
      sol1_lista   = 1'b0;
      resp0_valida = 1'b0;
      resp1_valida = 1'b0;
      alu_a        = '0;
      alu_b        = '0;
      senial_ALU   = OP_NOP;
      case (estado)
         LIBRE: begin
            sol0_lista = grant0;
            sol1_lista = grant1;
            if (grant0 || grant1)
               estado_sig = EJEC;
         end
         EJEC: begin
            alu_a      = a_q;
            alu_b      = b_q;
            senial_ALU = dec_code;
            estado_sig = RESP;
         end
         RESP: begin
            resp0_valida = !owner;
            resp1_valida = owner;
            if (aceptado)
               estado_sig = LIBRE;
         end
         default: estado_sig = LIBRE;
      endcase
   end

   assign resp0_resultado = resultado_q;
   assign resp1_resultado = resultado_q;
   assign resp0_error     = error_q;
   assign resp1_error     = error_q;

`ifdef CONTADOR_OPS_EN
   // Counts completed response handshakes, error responses included, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         ops0_total <= '0;
         ops1_total <= '0;
      end else begin
         if (resp0_valida && resp0_acepta && ops0_total != 16'hFFFF)
            ops0_total <= ops0_total + 16'd1;
         if (resp1_valida && resp1_acepta && ops1_total != 16'hFFFF)
            ops1_total <= ops1_total + 16'd1;
      end
   end
`endif

endmodule
